// File: rtl/stream_demux_n_pkg.sv
// Shared types and constants for the stream_demux_n block.
package stream_demux_pkg;

  localparam int STATE_W = 2;

  // Packet-tracking states of the input side.
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,  // no open packet, next beat is a first beat
    ST_ROUTE = 2'd1,  // packet locked to cur_sel
    ST_DROP  = 2'd2   // discarding a packet with an out-of-range select
  } state_e;

endpackage : stream_demux_pkg

// File: rtl/stream_demux_n_onehot_dec.sv
// Enabled binary-to-one-hot decoder, SEL_W bits to N lines; N need not be a power of 2.
module onehot_dec #(
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N)
) (
  input  logic [SEL_W-1:0] sel_i,
  input  logic             en_i,
  output logic [N-1:0]     dec_o
);

  // Drive line i when enabled and the select equals i; codes >= N light nothing.
  always_comb begin
    dec_o = '0;
    for (int i = 0; i < N; i++) begin
      if (en_i && (sel_i == i[SEL_W-1:0])) begin
        dec_o[i] = 1'b1;
      end else begin
        dec_o[i] = 1'b0;
      end
    end
  end

endmodule : onehot_dec

// File: rtl/stream_demux_n.sv
// 1-to-N valid/ready packet demultiplexer with a single registered output stage.
// The channel is chosen by in_sel on a packet's first beat; packets whose select
// is out of range are swallowed whole and counted in a saturating drop counter.
module stream_demux_n
  import stream_demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int N     = 8,
  parameter int SEL_W = $clog2(N),
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [SEL_W-1:0] in_sel,
  output logic [N-1:0]     out_valid,
  input  logic [N-1:0]     out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             busy
);

  state_e             state_q,    state_d;
  logic [SEL_W-1:0]   cur_sel_q,  cur_sel_d;
  logic               o_full_q,   o_full_d;
  logic [SEL_W-1:0]   o_sel_q,    o_sel_d;
  logic [WIDTH-1:0]   o_data_q,   o_data_d;
  logic               o_last_q,   o_last_d;
  logic [CNT_W-1:0]   drop_cnt_q, drop_cnt_d;

  logic               drain_s;
  logic               accept_s;
  logic               sel_ok_s;
  logic               load_s;
  logic [SEL_W-1:0]   load_sel_s;

  // Per-channel valid: only the channel held in the output register can be valid.
  onehot_dec #(
    .N     (N),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel_i (o_sel_q),
    .en_i  (o_full_q),
    .dec_o (out_valid)
  );

  // Handshake terms; ready of channels other than o_sel is masked by out_valid.
  always_comb begin
    drain_s  = |(out_valid & out_ready);
    sel_ok_s = (32'(in_sel) < 32'(N));
    if (state_q == ST_DROP) begin
      in_ready = 1'b1;
    end else begin
      in_ready = !o_full_q || drain_s;
    end
    accept_s = in_valid && in_ready;
  end

  // Packet FSM: decides where each accepted beat goes and counts dropped packets.
  always_comb begin
    state_d    = state_q;
    cur_sel_d  = cur_sel_q;
    drop_cnt_d = drop_cnt_q;
    load_s     = 1'b0;
    load_sel_s = cur_sel_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          if (sel_ok_s) begin
            load_s     = 1'b1;
            load_sel_s = in_sel;
            if (!in_last) begin
              state_d   = ST_ROUTE;
              cur_sel_d = in_sel;
            end else begin
              state_d   = ST_IDLE;
            end
          end else begin
            if (drop_cnt_q != {CNT_W{1'b1}}) begin
              drop_cnt_d = drop_cnt_q + CNT_W'(1);
            end else begin
              drop_cnt_d = drop_cnt_q;
            end
            if (!in_last) begin
              state_d = ST_DROP;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ROUTE: begin
        if (accept_s) begin
          load_s     = 1'b1;
          load_sel_s = cur_sel_q;
          if (in_last) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_ROUTE;
          end
        end else begin
          state_d = ST_ROUTE;
        end
      end
      ST_DROP: begin
        if (accept_s && in_last) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DROP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output register: a load wins over a drain so both can happen in one cycle.
  always_comb begin
    o_full_d = o_full_q;
    o_sel_d  = o_sel_q;
    o_data_d = o_data_q;
    o_last_d = o_last_q;
    if (load_s) begin
      o_full_d = 1'b1;
      o_sel_d  = load_sel_s;
      o_data_d = in_data;
      o_last_d = in_last;
    end else if (drain_s) begin
      o_full_d = 1'b0;
    end else begin
      o_full_d = o_full_q;
    end
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_sel_q  <= '0;
      o_full_q   <= 1'b0;
      o_sel_q    <= '0;
      o_data_q   <= '0;
      o_last_q   <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_sel_q  <= cur_sel_d;
      o_full_q   <= o_full_d;
      o_sel_q    <= o_sel_d;
      o_data_q   <= o_data_d;
      o_last_q   <= o_last_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign out_data = o_data_q;
  assign out_last = o_last_q;
  assign drop_cnt = drop_cnt_q;
  assign busy     = (state_q != ST_IDLE) || o_full_q;

endmodule : stream_demux_n

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: three instances (N=8, N=6, N=5/CNT_W=2).
module tb_stream_demux_n;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  // N=8 instance
  logic       v8, l8;
  logic [7:0] d8, or8;
  logic [2:0] s8;
  logic       rdy8, ol8, b8;
  logic [7:0] ov8, od8, dc8;

  // N=6 instance
  logic       v6, l6;
  logic [7:0] d6;
  logic [5:0] or6;
  logic [2:0] s6;
  logic       rdy6, ol6, b6;
  logic [5:0] ov6;
  logic [7:0] od6, dc6;

  // N=5, CNT_W=2 instance
  logic       v5, l5;
  logic [7:0] d5;
  logic [4:0] or5;
  logic [2:0] s5;
  logic       rdy5, ol5, b5;
  logic [4:0] ov5;
  logic [7:0] od5;
  logic [1:0] dc5;

  stream_demux_n #(.WIDTH(8), .N(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8), .in_data(d8), .in_last(l8),
    .in_sel(s8), .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_last(ol8),
    .drop_cnt(dc8), .busy(b8));

  stream_demux_n #(.WIDTH(8), .N(6), .CNT_W(8)) u6 (
    .clk(clk), .rst(rst), .in_valid(v6), .in_ready(rdy6), .in_data(d6), .in_last(l6),
    .in_sel(s6), .out_valid(ov6), .out_ready(or6), .out_data(od6), .out_last(ol6),
    .drop_cnt(dc6), .busy(b6));

  stream_demux_n #(.WIDTH(8), .N(5), .CNT_W(2)) u5 (
    .clk(clk), .rst(rst), .in_valid(v5), .in_ready(rdy5), .in_data(d5), .in_last(l5),
    .in_sel(s5), .out_valid(ov5), .out_ready(or5), .out_data(od5), .out_last(ol5),
    .drop_cnt(dc5), .busy(b5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    v8 = 1'b0; l8 = 1'b0; d8 = 8'h00; s8 = 3'd0; or8 = 8'hFF;
    v6 = 1'b0; l6 = 1'b0; d6 = 8'h00; s6 = 3'd0; or6 = 6'h3F;
    v5 = 1'b0; l5 = 1'b0; d5 = 8'h00; s5 = 3'd0; or5 = 5'h1F;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    // reset state
    chk("rst_ov",  ov8,  8'h00);
    chk("rst_od",  od8,  8'h00);
    chk("rst_ol",  ol8,  1'b0);
    chk("rst_dc",  dc8,  8'h00);
    chk("rst_rdy", rdy8, 1'b1);
    chk("rst_busy", b8,  1'b0);

    // 3-beat packet on channel 5, all ready
    v8 = 1'b1; d8 = 8'h11; l8 = 1'b0; s8 = 3'd5;
    #1 chk("a_rdy0", rdy8, 1'b1);
    tick(); chk("a_ov1", ov8, 8'h20); chk("a_od1", od8, 8'h11); chk("a_ol1", ol8, 1'b0);
    d8 = 8'h22;
    tick(); chk("a_ov2", ov8, 8'h20); chk("a_od2", od8, 8'h22); chk("a_ol2", ol8, 1'b0);
    d8 = 8'h33; l8 = 1'b1;
    tick(); chk("a_ov3", ov8, 8'h20); chk("a_od3", od8, 8'h33); chk("a_ol3", ol8, 1'b1);
    v8 = 1'b0;
    tick(); chk("a_ov4", ov8, 8'h00); chk("a_busy", b8, 1'b0);

    // select changes mid-packet: beats stay on channel 5
    v8 = 1'b1; d8 = 8'h44; l8 = 1'b0; s8 = 3'd5;
    tick(); chk("b_ov1", ov8, 8'h20); chk("b_od1", od8, 8'h44);
    d8 = 8'h55; s8 = 3'd2;
    tick(); chk("b_ov2", ov8, 8'h20); chk("b_od2", od8, 8'h55);
    d8 = 8'h66; l8 = 1'b1;
    tick(); chk("b_ov3", ov8, 8'h20); chk("b_od3", od8, 8'h66); chk("b_ol3", ol8, 1'b1);
    v8 = 1'b0;
    tick(); chk("b_ov4", ov8, 8'h00);

    // back-to-back single-beat packets 0,3,0
    v8 = 1'b1; l8 = 1'b1; s8 = 3'd0; d8 = 8'hA0;
    #1 chk("c_rdy0", rdy8, 1'b1);
    tick(); chk("c_ov1", ov8, 8'h01); chk("c_od1", od8, 8'hA0);
    s8 = 3'd3; d8 = 8'hA3;
    #1 chk("c_rdy1", rdy8, 1'b1);
    tick(); chk("c_ov2", ov8, 8'h08); chk("c_od2", od8, 8'hA3);
    s8 = 3'd0; d8 = 8'hB0;
    #1 chk("c_rdy2", rdy8, 1'b1);
    tick(); chk("c_ov3", ov8, 8'h01); chk("c_od3", od8, 8'hB0); chk("c_ol3", ol8, 1'b1);
    v8 = 1'b0;
    tick(); chk("c_ov4", ov8, 8'h00);

    // stall on channel 4 while other channels are ready
    or8 = 8'hEF;
    v8 = 1'b1; s8 = 3'd4; d8 = 8'hC1; l8 = 1'b0;
    tick(); chk("d_ov1", ov8, 8'h10); chk("d_od1", od8, 8'hC1);
    d8 = 8'hC2;
    for (int i = 0; i < 4; i++) begin
      chk("d_rdy_stall", rdy8, 1'b0);
      chk("d_od_stall",  od8,  8'hC1);
      chk("d_ov_stall",  ov8,  8'h10);
      tick();
    end
    or8 = 8'hFF;
    #1 chk("d_rdy_rel", rdy8, 1'b1);
    tick(); chk("d_ov2", ov8, 8'h10); chk("d_od2", od8, 8'hC2); chk("d_ol2", ol8, 1'b0);
    d8 = 8'hC3; l8 = 1'b1;
    tick(); chk("d_od3", od8, 8'hC3); chk("d_ol3", ol8, 1'b1);
    v8 = 1'b0;
    tick(); chk("d_ov4", ov8, 8'h00);

    // N=6: 2-beat packet to channel 7 is dropped, then channel 1 delivered
    v6 = 1'b1; s6 = 3'd7; d6 = 8'hD1; l6 = 1'b0;
    #1 chk("e_rdy0", rdy6, 1'b1);
    tick(); chk("e_ov1", ov6, 6'h00); chk("e_dc1", dc6, 8'd1); chk("e_busy1", b6, 1'b1);
    d6 = 8'hD2; l6 = 1'b1;
    #1 chk("e_rdy1", rdy6, 1'b1);
    tick(); chk("e_ov2", ov6, 6'h00); chk("e_dc2", dc6, 8'd1); chk("e_busy2", b6, 1'b0);
    s6 = 3'd1; d6 = 8'hE1; l6 = 1'b0;
    tick(); chk("e_ov3", ov6, 6'h02); chk("e_od3", od6, 8'hE1);
    d6 = 8'hE2; l6 = 1'b1;
    tick(); chk("e_ov4", ov6, 6'h02); chk("e_od4", od6, 8'hE2); chk("e_ol4", ol6, 1'b1);
    v6 = 1'b0;
    tick(); chk("e_ov5", ov6, 6'h00); chk("e_dc5", dc6, 8'd1);

    // N=5, CNT_W=2: five bad single-beat packets saturate the counter at 3
    v5 = 1'b1; l5 = 1'b1; d5 = 8'h5A;
    for (int i = 0; i < 5; i++) begin
      s5 = 3'(5 + (i % 3));
      tick();
      chk("f_dc", dc5, (i + 1 > 3) ? 3 : i + 1);
      chk("f_ov", ov5, 5'h00);
    end
    // open a packet on channel 2, then reset mid-packet
    s5 = 3'd2; d5 = 8'hF1; l5 = 1'b0;
    tick(); chk("g_ov1", ov5, 5'h04); chk("g_busy1", b5, 1'b1);
    d5 = 8'hF2;
    rst = 1'b1;
    #1;
    chk("g_rst_ov",  ov5,  5'h00);
    chk("g_rst_od",  od5,  8'h00);
    chk("g_rst_ol",  ol5,  1'b0);
    chk("g_rst_dc",  dc5,  2'd0);
    chk("g_rst_busy", b5,  1'b0);
    chk("g_rst_rdy", rdy5, 1'b1);
    rst = 1'b0;
    s5 = 3'd3; d5 = 8'hF3; l5 = 1'b1;
    tick(); chk("g_ov2", ov5, 5'h08); chk("g_od2", od5, 8'hF3); chk("g_ol2", ol5, 1'b1);
    v5 = 1'b0;
    tick(); chk("g_ov3", ov5, 5'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stream_demux_n
